// File: rtl/nonoff_scan_ctrl_pkg.sv
// Shared constants and state encoding for the on/off scan controller.
package nonoff_scan_ctrl_pkg;

  localparam int buffer_size = 32;

  localparam logic [buffer_size-1:0] V_th = 32'h7E00_0000;
  localparam logic [buffer_size-1:0] ETA  = 32'h00C1_0000;
  localparam logic [buffer_size-1:0] ONE  = 32'h0000_0001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scanState_t;

endpackage

// File: rtl/nonoff_detect.sv
// Combinational on/off threshold detector for one membrane word.
// Fires when the word is above V_th+ETA, or when it lies strictly within
// ETA of V_th; equality at either boundary does not fire.
module nonoff_detect
  import nonoff_scan_ctrl_pkg::*;
(
  input  logic [buffer_size-1:0] vMem,
  output logic                   flag
);

  logic [buffer_size-1:0] dV;
  logic [buffer_size-1:0] absdV;
  logic [buffer_size-1:0] upperTh;

  // modular distance to threshold, then the two unsigned compares
  always_comb begin
    dV      = V_th - vMem;
    absdV   = dV[buffer_size-1] ? (~dV + ONE) : dV;
    upperTh = V_th + ETA;
    flag    = (vMem > upperTh) || (absdV < ETA);
  end

endmodule

// File: rtl/nonoff_scan_ctrl.sv
// Sweep controller sharing one on/off detector across NUM_NEURONS words
// of an external membrane RAM, one neuron per cycle.
// Optional macro REFRACT_EN: per-neuron refractory down-counters that
// suppress a neuron for REF_SWEEPS sweeps after it spikes.
//
// state | meaning
// IDLE  | waiting for start (ignored during the done pulse)
// SCAN  | one RAM read per cycle, addresses 0..NUM_NEURONS-1
// DRAIN | no read; last data word returns from the RAM
// DONE  | last flag is in the shadow; publish it to spike_vec
module nonoff_scan_ctrl
  import nonoff_scan_ctrl_pkg::*;
#(
  parameter int NUM_NEURONS = 16,
  parameter int ADDR_W      = 4,
  parameter int REF_SWEEPS  = 3,
  parameter int REF_W       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [buffer_size-1:0] mem_rdata,
  output logic                   spike_valid,
  output logic [ADDR_W-1:0]      spike_idx,
  output logic                   spike_flag,
  output logic [NUM_NEURONS-1:0] spike_vec
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NEURONS - 1);

  scanState_t             state;
  scanState_t             stateNext;
  logic                   launch;
  logic [ADDR_W-1:0]      addr;
  logic                   rdValid;
  logic [ADDR_W-1:0]      rdIdx;
  logic                   rawFlag;
  logic                   evalFlag;
  logic [NUM_NEURONS-1:0] shadow;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // next state, busy and read-port drive
  always_comb begin
    stateNext = state;
    launch    = 1'b0;
    busy      = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    case (state)
      IDLE: begin
        // done is high in the cycle right after DONE; start there is dropped
        if (start && !done) begin
          launch    = 1'b1;
          stateNext = SCAN;
        end
      end
      SCAN: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  = addr;
        if (addr == LAST_ADDR) stateNext = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        stateNext = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // address counter, saturates at the last neuron
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    addr <= '0;
    else if (launch)                            addr <= '0;
    else if (state == SCAN && addr != LAST_ADDR) addr <= addr + ADDR_W'(1);
  end

  // track which neuron the returning RAM word belongs to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdValid <= 1'b0;
      rdIdx   <= '0;
    end else begin
      rdValid <= mem_rd_en;
      rdIdx   <= mem_addr;
    end
  end

  nonoff_detect uDetect (
    .vMem (mem_rdata),
    .flag (rawFlag)
  );

`ifdef REFRACT_EN
  logic [REF_W-1:0] refCnt [NUM_NEURONS];
  logic [REF_W-1:0] curCnt;

  assign curCnt   = refCnt[rdIdx];
  assign evalFlag = rawFlag && (curCnt == '0);

  // refractory down-counters, one step per evaluation of that neuron
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) refCnt[i] <= '0;
    end else if (rdValid) begin
      if (curCnt != '0) refCnt[rdIdx] <= curCnt - REF_W'(1);
      else if (rawFlag) refCnt[rdIdx] <= REF_W'(REF_SWEEPS);
    end
  end
`else
  assign evalFlag = rawFlag;
`endif

  // per-neuron result strobe and shadow vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_valid <= 1'b0;
      spike_idx   <= '0;
      spike_flag  <= 1'b0;
      shadow      <= '0;
    end else begin
      spike_valid <= rdValid;
      spike_flag  <= rdValid && evalFlag;
      if (rdValid) begin
        spike_idx     <= rdIdx;
        shadow[rdIdx] <= evalFlag;
      end
    end
  end

  // publish the completed sweep together with the done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done      <= 1'b0;
      spike_vec <= '0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) spike_vec <= shadow;
    end
  end

endmodule

// File: tb/tb_nonoff_scan_ctrl.sv
// Scoreboard bench for nonoff_scan_ctrl with a sweep-level reference model.
`timescale 1ns/1ps
module tb_nonoff_scan_ctrl;
  import nonoff_scan_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int RS = 3;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic          spike_valid;
  logic [AW-1:0] spike_idx;
  logic          spike_flag;
  logic [N-1:0]  spike_vec;

  nonoff_scan_ctrl #(.NUM_NEURONS(N), .ADDR_W(AW), .REF_SWEEPS(RS), .REF_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .spike_valid(spike_valid), .spike_idx(spike_idx), .spike_flag(spike_flag),
    .spike_vec(spike_vec)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; bit flag; int cyc; } strobe_t;
  typedef struct { logic [N-1:0] vec; int cyc; } doneExp_t;

  strobe_t      strobeQ[$];
  doneExp_t     doneQ[$];
  logic [31:0]  ram [N];
  int           refLeft [N];
  logic [N-1:0] lastVec = '0;
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: one-cycle read latency, junk when not reading
  always @(posedge clk) mem_rdata <= mem_rd_en ? ram[mem_addr] : $urandom();

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit refFlag(input logic [31:0] v);
    int     sd;
    longint mag;
    sd  = int'(V_th - v);
    mag = (sd < 0) ? -longint'(sd) : longint'(sd);
    return (longint'(v) > longint'(V_th) + longint'(ETA)) || (mag < longint'(ETA));
  endfunction

  // expected strobes and done for a sweep whose start is accepted in cycle s
  task automatic modelSweep(input int s);
    logic [N-1:0] vec;
    bit f;
    vec = '0;
    for (int i = 0; i < N; i++) begin
      f = refFlag(ram[i]);
`ifdef REFRACT_EN
      if (refLeft[i] > 0) begin
        f = 1'b0;
        refLeft[i]--;
      end else if (f) begin
        refLeft[i] = RS;
      end
`endif
      vec[i] = f;
      strobeQ.push_back('{i, f, s + 3 + i});
    end
    doneQ.push_back('{vec, s + N + 3});
  endtask

  // scoreboard monitor, samples on the falling edge
  always @(negedge clk) begin : mon
    strobe_t  se;
    doneExp_t de;
    if (!rst) begin
      if (spike_valid) begin
        if (strobeQ.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected strobe: idx %0d at cycle %0d, none expected", spike_idx, cyc);
        end else begin
          se = strobeQ.pop_front();
          check("strobe idx", spike_idx, se.idx);
          check("strobe flag", spike_flag, se.flag);
          check("strobe cycle", cyc, se.cyc);
        end
      end
      if (done) begin
        if (doneQ.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected done: at cycle %0d, none expected", cyc);
        end else begin
          de = doneQ.pop_front();
          check("done vec", spike_vec, de.vec);
          check("done cycle", cyc, de.cyc);
          lastVec = de.vec;
        end
      end else begin
        check("vec stable", spike_vec, lastVec);
      end
    end
  end

  task automatic waitUntil(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic launchSweep(output int s);
    @(posedge clk); #1;
    start = 1'b1;
    s = cyc;
    modelSweep(s);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic checkDrained(input string tag);
    check({tag, " strobes left"}, strobeQ.size(), 0);
    check({tag, " dones left"}, doneQ.size(), 0);
  endtask

  task automatic runSweep(input string tag);
    int s;
    launchSweep(s);
    waitUntil(s + N + 5);
    checkDrained(tag);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " mem_rd_en"}, mem_rd_en, 0);
    check({tag, " mem_addr"}, mem_addr, 0);
    check({tag, " spike_valid"}, spike_valid, 0);
    check({tag, " spike_idx"}, spike_idx, 0);
    check({tag, " spike_flag"}, spike_flag, 0);
    check({tag, " spike_vec"}, spike_vec, 0);
  endtask

  task automatic resetModel();
    strobeQ.delete();
    doneQ.delete();
    lastVec = '0;
    for (int i = 0; i < N; i++) refLeft[i] = 0;
  endtask

  task automatic pulseReset();
    @(posedge clk); #2;
    rst = 1'b1;
    resetModel();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] randWord();
    case ($urandom_range(0, 3))
      0:       return $urandom();
      1:       return V_th + ETA + 32'($urandom_range(0, 2)) - 32'd1;
      2:       return V_th - ETA + 32'($urandom_range(0, 2)) - 32'd1;
      default: return V_th - 2 * ETA + 32'($urandom_range(0, 4 * 32'h00C1_0000));
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  s;
    bit  pat [5];
    rst   = 1'b1;
    start = 1'b0;
    resetModel();
    for (int i = 0; i < N; i++) ram[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;

    // basic sweep
    ram[0] = 32'h7EC1_0001; ram[1] = 32'h7E00_0000;
    ram[2] = 32'h7D3F_0000; ram[3] = 32'h0000_0000;
    runSweep("basic");
    check("basic vec", spike_vec, 4'b0011);

    // boundaries
    ram[0] = 32'h7EC1_0000; ram[1] = 32'h7D3F_0001;
    ram[2] = 32'h7DFF_FFFF; ram[3] = 32'hFFFF_FFFF;
    runSweep("bound");
`ifndef REFRACT_EN
    check("bound vec", spike_vec, 4'b1110);
`endif

    // handshake: pulses at 0, 2 and 7 give one sweep
    for (int i = 0; i < N; i++) ram[i] = randWord();
    @(posedge clk); #1;
    start = 1'b1;
    s = cyc;
    modelSweep(s);
    for (int rel = 1; rel <= 9; rel++) begin
      @(posedge clk); #1;
      start = (rel == 2 || rel == 7);
      check("handshake busy", busy, (rel >= 1 && rel <= 6));
      if (rel == 7) check("handshake done", done, 1);
    end
    start = 1'b0;
    waitUntil(s + N + 8);
    checkDrained("handshake");

    // start held high through the done cycle re-triggers from IDLE
    for (int i = 0; i < N; i++) ram[i] = randWord();
    @(posedge clk); #1;
    start = 1'b1;
    s = cyc;
    modelSweep(s);
    modelSweep(s + 8);
    waitUntil(s + 9);
    start = 1'b0;
    waitUntil(s + 8 + N + 5);
    checkDrained("held start");

    // reset in cycle 4 of a sweep
    for (int i = 0; i < N; i++) ram[i] = randWord();
    launchSweep(s);
    waitUntil(s + 4);
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("mid reset");
    resetModel();
    @(posedge clk); @(posedge clk); #1;
    check("mid reset no done", done, 0);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("after reset no done", done, 0);
    end
    ram[0] = 32'h7E00_0000;
    runSweep("after reset");
    check("after reset vec0", spike_vec[0], 1);

    // refractory behaviour of neuron 0 from clean counters
`ifdef REFRACT_EN
    pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    pulseReset();
    for (int k = 0; k < 5; k++) begin
      ram[0] = V_th;
      for (int i = 1; i < N; i++) ram[i] = randWord();
      runSweep("refract");
      check("refract vec0", spike_vec[0], pat[k]);
    end

    // randomized sweeps
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < N; i++) ram[i] = randWord();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      runSweep("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
